// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch unit.
package if_prefetch_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int IBUS_DEPTH = 2;

    localparam logic [DATA_WIDTH-1:0] NOP              = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction bus: request/grant address phase, in-order read-data phase.
interface if_prefetch_if;

    logic                                  req;
    logic [if_prefetch_pkg::ADDR_WIDTH-1:0] addr;
    logic                                  gnt;
    logic                                  rvalid;
    logic [if_prefetch_pkg::DATA_WIDTH-1:0] rdata;

    // Fetch unit side.
    modport master (
        output req, addr,
        input  gnt, rvalid, rdata
    );

    // Memory / interconnect side.
    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/if_fifo.sv
// Small synchronous FIFO with flush; used for fetch tags and fetched data.
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop_i && (cnt_q != '0) && !flush_i;
        do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop) && !flush_i;
    end

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy decides what is readable.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited word fetches,
// buffers in-order responses and presents one instruction per cycle to decode.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                    DEPTH    = IBUS_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  jump_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    if_prefetch_if.master         ibus,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic [CW-1:0]         discard_q, discard_d;

    logic                  tag_push, tag_pop, tag_full, tag_empty;
    logic [ADDR_WIDTH-1:0] tag_head;
    logic [CW-1:0]         out_cnt;

    logic                  dat_push, dat_pop, dat_full, dat_empty;
    fetch_entry_t          dat_wdata, dat_head;
    logic [CW-1:0]         dat_cnt;

    logic                  drop;
    logic [SW-1:0]         credit_used;

    // Handshake decode. An entry leaving the buffer this cycle already frees its
    // slot, which is what lets a DEPTH=2 buffer sustain one instruction per cycle.
    always_comb begin
        dat_pop     = inst_valid_o && !stall_i;
        credit_used = SW'(dat_cnt) + SW'(out_cnt) - SW'(dat_pop);
        ibus.req    = !rst_i && !tag_full && !(dat_full && !dat_pop)
                      && (credit_used < SW'(DEPTH));
        ibus.addr   = fpc_q;
        tag_push    = ibus.req && ibus.gnt;
        tag_pop     = ibus.rvalid && !tag_empty;
        drop        = jump_i || (discard_q != '0);
        dat_push    = tag_pop && !drop;
        dat_wdata   = '{addr: tag_head, inst: ibus.rdata};
    end

    // Tag FIFO: one entry per granted request, so its occupancy is the
    // outstanding count, stale (to-be-discarded) requests included.
    if_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_WIDTH)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tag_push),
        .pop_i   (tag_pop),
        .flush_i (1'b0),
        .wdata_i (fpc_q),
        .rdata_o (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (out_cnt)
    );

    // Data FIFO: returned instructions paired with their fetch address.
    if_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_dat_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (dat_push),
        .pop_i   (dat_pop),
        .flush_i (jump_i),
        .wdata_i (dat_wdata),
        .rdata_o (dat_head),
        .full_o  (dat_full),
        .empty_o (dat_empty),
        .count_o (dat_cnt)
    );

    // Next PC and discard budget; a redirect overrides the sequential increment
    // and marks every request still in flight after this cycle as stale.
    always_comb begin
        fpc_d     = fpc_q;
        discard_d = discard_q;
        if (jump_i) begin
            fpc_d     = word_align(jump_addr_i);
            discard_d = out_cnt + CW'(tag_push) - CW'(tag_pop);
        end else begin
            if (tag_push)                           fpc_d     = fpc_q + ADDR_WIDTH'(4);
            if (tag_pop && (discard_q != '0))       discard_d = discard_q - 1'b1;
        end
    end

    // PC and discard registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fpc_q     <= word_align(RESET_PC);
            discard_q <= '0;
        end else begin
            fpc_q     <= fpc_d;
            discard_q <= discard_d;
        end
    end

    // Present the FIFO head; NOP and a zero PC when nothing is buffered.
    always_comb begin
        inst_valid_o = !dat_empty;
        inst_o       = dat_empty ? NOP : dat_head.inst;
        inst_addr_o  = dat_empty ? '0  : dat_head.addr;
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed, table-driven bench for if_prefetch with an in-order bus responder.
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, jump_i;
    logic [31:0] jump_addr_i;
    logic        inst_valid_o;
    logic [31:0] inst_o, inst_addr_o;

    if_prefetch_if bus();

    if_prefetch dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .ibus         (bus),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        int          rst, stall, jump, gnt, lat;
        logic [31:0] jaddr;
        int          ev;
        logic [31:0] ea;
        int          er;
        logic [31:0] eia;
    } vec_t;

    pend_t q[$];
    vec_t  tbl[18];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    lat_cur  = 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic vec_t mk(input int rst, stall, jump, gnt, lat,
                                input logic [31:0] jaddr, input int ev,
                                input logic [31:0] ea, input int er,
                                input logic [31:0] eia);
        vec_t v;
        v.rst = rst; v.stall = stall; v.jump = jump; v.gnt = gnt; v.lat = lat;
        v.jaddr = jaddr; v.ev = ev; v.ea = ea; v.er = er; v.eia = eia;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h want %h", nm, id, got, exp);
        end
    endtask

    // Advance one clock; the bus model records grants and returns responses in order.
    task automatic tick(input int lat);
        logic        granted, resp, was_rst;
        logic [31:0] gaddr;
        granted = bus.req && bus.gnt;
        gaddr   = bus.addr;
        resp    = bus.rvalid;
        was_rst = rst_i;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) q.delete();
        else begin
            if (resp && q.size() > 0) q.delete(0);
            if (granted) q.push_back('{addr: gaddr, due: cyc - 1 + lat});
        end
        if (q.size() > 0 && q[0].due <= cyc) begin
            bus.rvalid = 1'b1;
            bus.rdata  = mem(q[0].addr);
        end else begin
            bus.rvalid = 1'b0;
            bus.rdata  = '0;
        end
    endtask

    task automatic row(input int id, input vec_t v);
        rst_i       = (v.rst != 0);
        stall_i     = (v.stall != 0);
        jump_i      = (v.jump != 0);
        jump_addr_i = v.jaddr;
        bus.gnt     = (v.gnt != 0);
        #1;
        chk("inst_valid", id, {31'b0, inst_valid_o}, 32'(v.ev));
        chk("inst",       id, inst_o, (v.ev != 0) ? mem(v.ea) : NOP);
        chk("inst_addr",  id, inst_addr_o, v.ea);
        chk("ibus_req",   id, {31'b0, bus.req}, 32'(v.er));
        chk("ibus_addr",  id, bus.addr, v.eia);
        tick(v.lat);
    endtask

    task automatic step(input int id, input int jump, input logic [31:0] jaddr,
                        input int ev, input logic [31:0] ea, input int er,
                        input logic [31:0] eia);
        row(id, mk(0, 0, jump, 1, lat_cur, jaddr, ev, ea, er, eia));
    endtask

    task automatic do_reset();
        rst_i = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0; bus.gnt = 1'b1;
        tick(1);
        tick(1);
    endtask

    initial begin
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        do_reset();
        #1;
        chk("rst_req",       0, {31'b0, bus.req}, 32'd0);
        chk("rst_addr",      0, bus.addr, RESET_PC_DEFAULT);
        chk("rst_valid",     0, {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst",      0, inst_o, NOP);
        chk("rst_inst_addr", 0, inst_addr_o, 32'd0);

        // Reset release, 1-cycle bus, one held-off grant, 5-cycle stall, then reset with a full buffer.
        tbl[0]  = mk(0,0,0,0,1, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0,0,0,1,1, 0, 0, 0, 1, 0);
        tbl[2]  = mk(0,0,0,1,1, 0, 0, 0, 1, 4);
        tbl[3]  = mk(0,0,0,1,1, 0, 1, 0, 1, 8);
        tbl[4]  = mk(0,0,0,1,1, 0, 1, 4, 1, 12);
        tbl[5]  = mk(0,0,0,1,1, 0, 1, 8, 1, 16);
        for (int i = 6; i <= 10; i++) tbl[i] = mk(0,1,0,1,1, 0, 1, 12, 0, 20);
        tbl[11] = mk(0,0,0,1,1, 0, 1, 12, 1, 20);
        tbl[12] = mk(0,0,0,1,1, 0, 1, 16, 1, 24);
        tbl[13] = mk(0,0,0,1,1, 0, 1, 20, 1, 28);
        tbl[14] = mk(0,1,0,1,1, 0, 1, 24, 0, 32);
        tbl[15] = mk(0,1,0,1,1, 0, 1, 24, 0, 32);
        tbl[16] = mk(1,1,0,1,1, 0, 1, 24, 0, 32);
        tbl[17] = mk(1,0,0,1,1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) row(i, tbl[i]);

        // Jump to 0x100 with two requests in flight on a 3-cycle bus.
        do_reset();
        lat_cur = 3;
        step(100, 0, 0,         0, 0,         1, 0);
        step(101, 0, 0,         0, 0,         1, 4);
        step(102, 1, 32'h100,   0, 0,         0, 8);
        step(103, 0, 0,         0, 0,         0, 32'h100);
        step(104, 0, 0,         0, 0,         1, 32'h100);
        step(105, 0, 0,         0, 0,         1, 32'h104);
        step(106, 0, 0,         0, 0,         0, 32'h108);
        step(107, 0, 0,         0, 0,         0, 32'h108);
        step(108, 0, 0,         1, 32'h100,   1, 32'h108);
        step(109, 0, 0,         1, 32'h104,   1, 32'h10C);

        // Jump coinciding with rvalid and gnt, misaligned target, jump-during-discard, PC wrap.
        do_reset();
        lat_cur = 2;
        step(200, 0, 0,             0, 0,             1, 0);
        step(201, 0, 0,             0, 0,             1, 4);
        step(202, 0, 0,             0, 0,             0, 8);
        step(203, 1, 32'h200,       1, 0,             1, 8);
        step(204, 0, 0,             0, 0,             1, 32'h200);
        step(205, 0, 0,             0, 0,             0, 32'h204);
        step(206, 0, 0,             0, 0,             1, 32'h204);
        step(207, 1, 32'h103,       1, 32'h200,       1, 32'h208);
        step(208, 0, 0,             0, 0,             0, 32'h100);
        step(209, 1, 32'hFFFF_FFFC, 0, 0,             1, 32'h100);
        step(210, 0, 0,             0, 0,             1, 32'hFFFF_FFFC);
        step(211, 0, 0,             0, 0,             0, 0);
        step(212, 0, 0,             0, 0,             1, 0);
        step(213, 0, 0,             1, 32'hFFFF_FFFC, 1, 4);
        step(214, 0, 0,             0, 0,             0, 8);
        step(215, 0, 0,             1, 0,             1, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
